// File: rtl/fsm_pkg.sv
// Shared constants for the multicycle CPU control FSM: state encodings,
// opcode classes, control-bus bit positions and field widths.
package fsm_pkg;

    localparam int unsigned OPC_W   = 4;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned CTRL_W  = 8;

    // Codes 3'b110 / 3'b111 are unused and recover to FETCH.
    typedef enum logic [STATE_W-1:0] {
        ST_FETCH     = 3'b000,
        ST_DECODE    = 3'b001,
        ST_EXECUTE   = 3'b010,
        ST_MEMORY    = 3'b011,
        ST_WRITEBACK = 3'b100,
        ST_HALT      = 3'b101
    } state_e;

    // Opcode classes; 4'b0111..4'b1110 are illegal and behave as NOP.
    localparam logic [OPC_W-1:0] OPC_ALU_R  = 4'b0000;
    localparam logic [OPC_W-1:0] OPC_ALU_I  = 4'b0001;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 4'b0010;
    localparam logic [OPC_W-1:0] OPC_STORE  = 4'b0011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 4'b0100;
    localparam logic [OPC_W-1:0] OPC_JUMP   = 4'b0101;
    localparam logic [OPC_W-1:0] OPC_LUI    = 4'b0110;
    localparam logic [OPC_W-1:0] OPC_HALT   = 4'b1111;

    // Bit positions within control_signals.
    localparam int unsigned CB_IR_WRITE    = 0;
    localparam int unsigned CB_PC_WRITE    = 1;
    localparam int unsigned CB_REG_READ    = 2;
    localparam int unsigned CB_ALU_EN      = 3;
    localparam int unsigned CB_ALU_SRC_IMM = 4;
    localparam int unsigned CB_MEM_READ    = 5;
    localparam int unsigned CB_MEM_WRITE   = 6;
    localparam int unsigned CB_REG_WRITE   = 7;

endpackage

// File: rtl/fsm_if.sv
// Decoder/datapath-facing bundle of the control FSM.
//   opcode          : instruction class from the decoder (sampled in DECODE)
//   state           : current FSM state encoding
//   control_signals : datapath strobes
// master = decoder/datapath side, slave = the FSM.
interface fsm_if;
    import fsm_pkg::*;

    logic [OPC_W-1:0]   opcode;
    logic [STATE_W-1:0] state;
    logic [CTRL_W-1:0]  control_signals;

    modport master (
        output opcode,
        input  state,
        input  control_signals
    );

    modport slave (
        input  opcode,
        output state,
        output control_signals
    );
endinterface

// File: rtl/fsm_ctrl_decode.sv
// Combinational map from (state, latched opcode class) to datapath strobes.
//   state_i : current FSM state
//   opc_i   : opcode class latched when leaving DECODE
//   ctrl_o  : control strobes (bit meanings in fsm_pkg CB_* constants)
module fsm_ctrl_decode
    import fsm_pkg::*;
(
    input  state_e            state_i,
    input  logic [OPC_W-1:0]  opc_i,
    output logic [CTRL_W-1:0] ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            ST_FETCH: begin
                ctrl_o[CB_IR_WRITE] = 1'b1;
                ctrl_o[CB_PC_WRITE] = 1'b1;
            end
            ST_DECODE: begin
                ctrl_o[CB_REG_READ] = 1'b1;
            end
            ST_EXECUTE: begin
                case (opc_i)
                    OPC_ALU_R, OPC_BRANCH: begin
                        ctrl_o[CB_ALU_EN] = 1'b1;
                    end
                    OPC_ALU_I, OPC_LOAD, OPC_STORE, OPC_LUI: begin
                        ctrl_o[CB_ALU_EN]      = 1'b1;
                        ctrl_o[CB_ALU_SRC_IMM] = 1'b1;
                    end
                    // Jump target is computed by the ALU and written to PC.
                    OPC_JUMP: begin
                        ctrl_o[CB_ALU_EN]   = 1'b1;
                        ctrl_o[CB_PC_WRITE] = 1'b1;
                    end
                    OPC_HALT: begin
                        ctrl_o = '0;
                    end
                    default: begin
                        ctrl_o = '0;
                    end
                endcase
            end
            ST_MEMORY: begin
                if (opc_i == OPC_LOAD) begin
                    ctrl_o[CB_MEM_READ] = 1'b1;
                end else if (opc_i == OPC_STORE) begin
                    ctrl_o[CB_MEM_WRITE] = 1'b1;
                end
            end
            ST_WRITEBACK: begin
                ctrl_o[CB_REG_WRITE] = 1'b1;
            end
            ST_HALT: begin
                ctrl_o = '0;
            end
            default: begin
                ctrl_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/fsm.sv
// Multicycle CPU control FSM: FETCH -> DECODE -> EXECUTE -> [MEMORY] ->
// [WRITEBACK] -> FETCH, one transition per clock.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : fsm_if.slave (opcode in, state / control_signals out)
// Optional feature: define FSM_HALT_EN to make opcode 4'b1111 enter a HALT
// state held until reset; otherwise 4'b1111 behaves as a NOP.
module fsm
    import fsm_pkg::*;
(
    input  logic clk,
    input  logic reset,
    fsm_if.slave bus
);

    state_e            state_q;
    state_e            state_d;
    logic [OPC_W-1:0]  opc_q;
    logic [OPC_W-1:0]  opc_d;
    logic [CTRL_W-1:0] ctrl_c;

    // State and latched-opcode registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FETCH;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
        end
    end

    // Next-state logic; the opcode is captured only on the edge leaving DECODE.
    always_comb begin
        state_d = ST_FETCH;
        opc_d   = opc_q;
        case (state_q)
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = ST_EXECUTE;
                opc_d   = bus.opcode;
            end
            ST_EXECUTE: begin
                case (opc_q)
                    OPC_LOAD, OPC_STORE: begin
                        state_d = ST_MEMORY;
                    end
                    OPC_ALU_R, OPC_ALU_I, OPC_JUMP, OPC_LUI: begin
                        state_d = ST_WRITEBACK;
                    end
`ifdef FSM_HALT_EN
                    OPC_HALT: begin
                        state_d = ST_HALT;
                    end
`else
                    OPC_HALT: begin
                        state_d = ST_FETCH;
                    end
`endif
                    default: begin
                        state_d = ST_FETCH;
                    end
                endcase
            end
            ST_MEMORY: begin
                state_d = (opc_q == OPC_LOAD) ? ST_WRITEBACK : ST_FETCH;
            end
            ST_WRITEBACK: begin
                state_d = ST_FETCH;
            end
            ST_HALT: begin
`ifdef FSM_HALT_EN
                state_d = ST_HALT;
`else
                state_d = ST_FETCH;
`endif
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    fsm_ctrl_decode u_ctrl_decode (
        .state_i (state_q),
        .opc_i   (opc_q),
        .ctrl_o  (ctrl_c)
    );

    assign bus.state = state_q;
    // Reset gates the strobes directly so they drop without waiting for a clock.
    assign bus.control_signals = reset ? ctrl_c : '0;

endmodule

// File: tb/tb_fsm.sv
// Self-checking bench for fsm: table of per-cycle vectors plus hand-written
// sequences for async reset and the HALT opcode.
module tb_fsm;

    logic clk;
    logic reset;

    fsm_if u_if ();

    fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] opc;
        logic [2:0] st;
        logic [7:0] ct;
        string      name;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void add(input logic [3:0] o, input logic [2:0] s,
                                input logic [7:0] c, input string n);
        vec_t v;
        v.opc  = o;
        v.st   = s;
        v.ct   = c;
        v.name = n;
        vecs.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [2:0] s, input logic [7:0] c);
        n_checks++;
        if (u_if.state !== s) begin
            n_fail++;
            $display("FAIL %s state: got %b expected %b", nm, u_if.state, s);
        end
        n_checks++;
        if (u_if.control_signals !== c) begin
            n_fail++;
            $display("FAIL %s control: got %h expected %h", nm, u_if.control_signals, c);
        end
    endtask

    // Drive opcode mid-cycle, take one rising edge, sample 1 ns later.
    task automatic step(input logic [3:0] o, input logic [2:0] s,
                        input logic [7:0] c, input string nm);
        u_if.opcode = o;
        @(posedge clk);
        #1;
        check(nm, s, c);
    endtask

    initial begin
        // Each vector: opcode applied before the edge, state/control after it.
        // ALU-R (opcode 0000): 4 cycles
        add(4'h0, 3'd1, 8'h04, "alur_dec");
        add(4'h0, 3'd2, 8'h08, "alur_exe");
        add(4'h0, 3'd4, 8'h80, "alur_wb");
        add(4'h0, 3'd0, 8'h03, "alur_fetch");
        // LOAD: 5 cycles
        add(4'h2, 3'd1, 8'h04, "load_dec");
        add(4'h2, 3'd2, 8'h18, "load_exe");
        add(4'h2, 3'd3, 8'h20, "load_mem");
        add(4'h2, 3'd4, 8'h80, "load_wb");
        add(4'h2, 3'd0, 8'h03, "load_fetch");
        // STORE: 4 cycles
        add(4'h3, 3'd1, 8'h04, "store_dec");
        add(4'h3, 3'd2, 8'h18, "store_exe");
        add(4'h3, 3'd3, 8'h40, "store_mem");
        add(4'h3, 3'd0, 8'h03, "store_fetch");
        // BRANCH: 3 cycles
        add(4'h4, 3'd1, 8'h04, "br_dec");
        add(4'h4, 3'd2, 8'h08, "br_exe");
        add(4'h4, 3'd0, 8'h03, "br_fetch");
        // ALU-I
        add(4'h1, 3'd1, 8'h04, "alui_dec");
        add(4'h1, 3'd2, 8'h18, "alui_exe");
        add(4'h1, 3'd4, 8'h80, "alui_wb");
        add(4'h1, 3'd0, 8'h03, "alui_fetch");
        // JUMP
        add(4'h5, 3'd1, 8'h04, "jmp_dec");
        add(4'h5, 3'd2, 8'h0A, "jmp_exe");
        add(4'h5, 3'd4, 8'h80, "jmp_wb");
        add(4'h5, 3'd0, 8'h03, "jmp_fetch");
        // LUI
        add(4'h6, 3'd1, 8'h04, "lui_dec");
        add(4'h6, 3'd2, 8'h18, "lui_exe");
        add(4'h6, 3'd4, 8'h80, "lui_wb");
        add(4'h6, 3'd0, 8'h03, "lui_fetch");
        // Illegal opcodes at both ends of the illegal range act as NOP
        add(4'h7, 3'd1, 8'h04, "ill7_dec");
        add(4'h7, 3'd2, 8'h00, "ill7_exe");
        add(4'h7, 3'd0, 8'h03, "ill7_fetch");
        add(4'hE, 3'd1, 8'h04, "illE_dec");
        add(4'hE, 3'd2, 8'h00, "illE_exe");
        add(4'hE, 3'd0, 8'h03, "illE_fetch");
        // Opcode stability: LOAD presented in FETCH, ALU-R at capture,
        // then LOAD again during EXECUTE -> no MEMORY visit
        add(4'h2, 3'd1, 8'h04, "stab_dec");
        add(4'h0, 3'd2, 8'h08, "stab_exe");
        add(4'h2, 3'd4, 8'h80, "stab_wb");
        add(4'h2, 3'd0, 8'h03, "stab_fetch");

        // Reset held across a clock edge
        reset       = 1'b0;
        u_if.opcode = 4'h0;
        #10;
        check("reset_hold", 3'd0, 8'h00);
        #2;
        reset = 1'b1;
        #1;
        check("reset_release", 3'd0, 8'h03);

        foreach (vecs[i]) begin
            step(vecs[i].opc, vecs[i].st, vecs[i].ct, vecs[i].name);
        end

        // Async reset between edges while in MEMORY
        step(4'h2, 3'd1, 8'h04, "ar_dec");
        step(4'h2, 3'd2, 8'h18, "ar_exe");
        step(4'h2, 3'd3, 8'h20, "ar_mem");
        #3;
        reset = 1'b0;
        #1;
        check("ar_immediate", 3'd0, 8'h00);
        #1;
        reset = 1'b1;
        #1;
        check("ar_release", 3'd0, 8'h03);
        step(4'h0, 3'd1, 8'h04, "ar_resume_dec");
        step(4'h0, 3'd2, 8'h08, "ar_resume_exe");
        step(4'h0, 3'd4, 8'h80, "ar_resume_wb");
        step(4'h0, 3'd0, 8'h03, "ar_resume_fetch");

        // HALT opcode
        step(4'hF, 3'd1, 8'h04, "halt_dec");
        step(4'hF, 3'd2, 8'h00, "halt_exe");
`ifdef FSM_HALT_EN
        for (int k = 0; k < 12; k++) begin
            step(4'h0, 3'd5, 8'h00, "halt_hold");
        end
        #2;
        reset = 1'b0;
        #1;
        check("halt_reset", 3'd0, 8'h00);
        #1;
        reset = 1'b1;
        #1;
        check("halt_release", 3'd0, 8'h03);
`else
        step(4'h0, 3'd0, 8'h03, "halt_nop_fetch");
`endif
        step(4'h0, 3'd1, 8'h04, "post_halt_dec");
        step(4'h4, 3'd2, 8'h08, "post_halt_exe");
        step(4'h4, 3'd0, 8'h03, "post_halt_fetch");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
